// File: rtl/mul_div_unit_if.sv
// Request/response bundle for mul_div_unit: one request channel carrying
// op select and operands, one response channel carrying result and the
// unsupported-op flag.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      fun3;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] Result;
  logic            illegal;

  modport master (
    output req_valid, fun3, A, B, resp_ready,
    input  req_ready, resp_valid, Result, illegal
  );

  modport slave (
    input  req_valid, fun3, A, B, resp_ready,
    output req_ready, resp_valid, Result, illegal
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV-style multiply/divide unit. One op in flight; multiply is
// radix-2 shift-add over XLEN cycles, divide is restoring division on
// magnitudes over XLEN cycles with sign fix-up on the final step.
// Optional divider: define MUL_DIV_UNIT_DIV_EN to build DIV/DIVU/REM/REMU;
// without it, fun3 = 1xx completes in one cycle flagged illegal.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          reset,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;    // {hi, lo}: product, or {rem, quo}
  logic [XLEN-1:0]   opb_q, opb_d;    // multiplicand or divisor magnitude
  logic [2:0]        op_q, op_d;
  logic              qneg_q, qneg_d;  // negate product / quotient
  logic [XLEN-1:0]   res_q, res_d;
  logic              ill_q, ill_d;

  // Operand sign handling at accept time
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  // Multiply step
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] mul_next, mul_fin;
  logic [XLEN-1:0]   mul_res;

`ifdef MUL_DIV_UNIT_DIV_EN
  logic              rneg_q, rneg_d;  // remainder follows dividend sign
  logic [XLEN:0]     dshift, dtry;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo, rem, div_res;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
`endif

  // Datapath: operand magnitudes and one iteration of each algorithm
  always_comb begin
    a_sgn = bus.fun3[2] ? ~bus.fun3[0] : (bus.fun3[1:0] == 2'b01 || bus.fun3[1:0] == 2'b10);
    b_sgn = bus.fun3[2] ? ~bus.fun3[0] : (bus.fun3[1:0] == 2'b01);
    a_neg = a_sgn & bus.A[XLEN-1];
    b_neg = b_sgn & bus.B[XLEN-1];
    a_mag = a_neg ? -bus.A : bus.A;
    b_mag = b_neg ? -bus.B : bus.B;

    msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
    mul_next = {msum, acc_q[XLEN-1:1]};
    mul_fin  = qneg_q ? -mul_next : mul_next;
    mul_res  = (op_q[1:0] == 2'b00) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
`ifdef MUL_DIV_UNIT_DIV_EN
    dshift   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    dtry     = dshift - {1'b0, opb_q};
    div_next = dtry[XLEN] ? {dshift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                          : {dtry[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
    quo      = div_next[XLEN-1:0];
    rem      = div_next[2*XLEN-1:XLEN];
    div_res  = op_q[1] ? (rneg_q ? -rem : rem) : (qneg_q ? -quo : quo);
`endif
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    res_d   = res_q;
    ill_d   = ill_q;
`ifdef MUL_DIV_UNIT_DIV_EN
    rneg_d  = rneg_q;
`endif
    bus.req_ready  = (state_q == S_IDLE);
    bus.resp_valid = (state_q == S_DONE);
    bus.Result     = res_q;
    bus.illegal    = ill_q;

    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        op_d  = bus.fun3;
        cnt_d = '0;
        if (!bus.fun3[2]) begin
          acc_d   = {{XLEN{1'b0}}, b_mag};
          opb_d   = a_mag;
          qneg_d  = a_neg ^ b_neg;
          state_d = S_MUL;
        end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
          ill_d = 1'b0;
          if (bus.B == '0) begin
            res_d   = bus.fun3[1] ? bus.A : {XLEN{1'b1}};
            state_d = S_DONE;
          end else if (!bus.fun3[0] && bus.A == SMIN && bus.B == {XLEN{1'b1}}) begin
            res_d   = bus.fun3[1] ? {XLEN{1'b0}} : bus.A;
            state_d = S_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            opb_d   = b_mag;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = S_DIV;
          end
`else
          res_d   = '0;
          ill_d   = 1'b1;
          state_d = S_DONE;
`endif
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          res_d   = mul_res;
          ill_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
`ifdef MUL_DIV_UNIT_DIV_EN
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          res_d   = div_res;
          ill_d   = 1'b0;
          state_d = S_DONE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: if (bus.resp_ready) begin
        ill_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any op and clears the visible outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      res_q   <= '0;
      ill_q   <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
`ifdef MUL_DIV_UNIT_DIV_EN
      rneg_q  <= rneg_d;
`endif
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (XLEN = 32). The driver pushes the
// expected result, illegal flag and first-valid cycle on each accept; the
// monitor checks latency, stability under backpressure and the result at
// each response handshake.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  mul_div_unit_if #(.XLEN(32)) bus ();

  mul_div_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on rising valid, hold stability, result at handshake
  logic        prev_v = 1'b0;
  logic [31:0] prev_res = '0;
  logic        prev_ill = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (bus.resp_valid) begin
        chk1("req_ready_low_in_done", bus.req_ready, 1'b0);
        if (!prev_v) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_response: got 0x%08h expected none (cycle %0d)", bus.Result, cyc);
          end else begin
            chk32("latency", 32'(cyc), 32'(sb[0].cyc));
          end
        end else begin
          chk32("result_stable", bus.Result, prev_res);
          chk1("illegal_stable", bus.illegal, prev_ill);
        end
        if (bus.resp_ready && sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk32("result", bus.Result, e.res);
          chk1("illegal", bus.illegal, e.ill);
        end
      end else begin
        chk1("illegal_idle", bus.illegal, 1'b0);
      end
      prev_v   = bus.resp_valid && !bus.resp_ready;
      prev_res = bus.Result;
      prev_ill = bus.illegal;
    end
  end

  // Present one request; lat is cycles from accept to first resp_valid
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat, input bit track);
    int   n = 0;
    logic ill = 1'b0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: got req_ready=0 expected 1 (cycle %0d)", cyc);
      return;
    end
`ifndef MUL_DIV_UNIT_DIV_EN
    if (f[2]) begin
      r   = '0;
      lat = 1;
      ill = 1'b1;
    end
`endif
    if (track) sb.push_back('{res: r, ill: ill, cyc: cyc + lat});
    bus.req_valid = 1'b1;
    bus.fun3      = f;
    bus.A         = a;
    bus.B         = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.fun3      = 3'($urandom);
    bus.A         = $urandom;
    bus.B         = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    bus.fun3       = '0;
    bus.A          = '0;
    bus.B          = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("reset_req_ready", bus.req_ready, 1'b1);
    chk1("reset_resp_valid", bus.resp_valid, 1'b0);
    chk32("reset_result", bus.Result, 32'h0);
    chk1("reset_illegal", bus.illegal, 1'b0);

    // Multiply class
    issue(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b1);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b1);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b1);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b1);
    issue(3'b010, 32'd2,        32'h8000_0000, 32'h0000_0001, 33, 1'b1);
    issue(3'b000, 32'd3,        32'd4,         32'd12,        33, 1'b1);

    // Divide class (flagged illegal with zero result when not built)
    issue(3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, 1'b1);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, 1'b1);
    issue(3'b101, 32'd100,       32'd7,        32'd14,        33, 1'b1);
    issue(3'b111, 32'd100,       32'd7,        32'd2,         33, 1'b1);
    issue(3'b101, 32'd5,         32'd0,        32'hFFFF_FFFF, 1,  1'b1);
    issue(3'b110, 32'd5,         32'd0,        32'd5,         1,  1'b1);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        1,  1'b1);
    issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        33, 1'b1);
    issue(3'b100, 32'd10,        32'd2,        32'd5,         33, 1'b1);
    drain();

    // Backpressure: consumer stalls for 3 cycles after valid rises
    bus.resp_ready = 1'b0;
    issue(3'b000, 32'd9, 32'd9, 32'd81, 33, 1'b1);
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk1("bp_valid_seen", bus.resp_valid, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) bus.resp_ready = 1'b1;
      @(negedge clk);
      chk1("bp_valid_held", bus.resp_valid, 1'b1);
      chk1("bp_req_ready_low", bus.req_ready, 1'b0);
    end
    @(negedge clk);
    chk1("bp_after_req_ready", bus.req_ready, 1'b1);
    chk1("bp_after_resp_valid", bus.resp_valid, 1'b0);
    drain();

    // Reset mid-multiply: aborted with no response, then a clean op
    issue(3'b000, 32'd123, 32'd456, 32'd0, 33, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("abort_req_ready", bus.req_ready, 1'b1);
    chk1("abort_resp_valid", bus.resp_valid, 1'b0);
    chk32("abort_result", bus.Result, 32'h0);
    repeat (40) @(negedge clk);
    chk1("abort_no_resp", bus.resp_valid, 1'b0);
    issue(3'b000, 32'd123, 32'd456, 32'd56088, 33, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
